// File: rtl/cd_link_sched_if.sv
// CD link bundle between the scheduler, its two on-core requesters and the
// HPS extension bus. The master side drives requests and incoming HPS
// commands. The slave side is the scheduler itself.
interface cd_link_sched_if;
  logic        req0_valid;
  logic [47:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [47:0] req1_data;
  logic        req1_ready;
  logic [48:0] cd_in;
  logic [48:0] cd_out;
  logic        cmd_valid;
  logic [47:0] cmd_data;
  logic        timeout_evt;
  logic        busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, cd_out,
    input  req0_ready, req1_ready, cd_in, cmd_valid, cmd_data, timeout_evt, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, cd_out,
    output req0_ready, req1_ready, cd_in, cmd_valid, cmd_data, timeout_evt, busy
  );
endinterface

// File: rtl/cd_link_sched.sv
// CD link message scheduler.
// Round-robin arbitration of two requesters onto the 49-bit cd_in toggle
// channel. Each message is held until the HPS replies with a cd_out toggle
// or until TIMEOUT cycles pass. A GAP idle period follows each message.
// Every cd_out toggle is turned into a one-cycle cmd_valid strobe with the
// command latched on cmd_data.
module cd_link_sched #(
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter int unsigned GAP     = 2
) (
  input  logic            clk_sys,
  input  logic            reset,
  cd_link_sched_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = {GAP_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               last_grant_r;
  logic               old_tog_r;
  logic               primed_r;
  logic [48:0]        cd_in_r;
  logic               cmd_valid_r;
  logic [47:0]        cmd_data_r;
  logic               timeout_evt_r;
  logic               busy_r;

  logic               toggle_s;
  logic               xfer_s;
  logic               grant_idx_s;
  logic [47:0]        grant_data_s;
  logic               timeout_s;

  // A cd_out toggle counts only once old_tog holds a real sample.
  assign toggle_s = primed_r & (bus.cd_out[48] ^ old_tog_r);

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state, grant selection and timeout detection.
  always_comb begin
    state_nx_s   = state_r;
    xfer_s       = 1'b0;
    grant_idx_s  = last_grant_r;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          // Tie: the requester not served last time wins.
          xfer_s      = 1'b1;
          grant_idx_s = ~last_grant_r;
        end else if (bus.req0_valid) begin
          xfer_s      = 1'b1;
          grant_idx_s = 1'b0;
        end else if (bus.req1_valid) begin
          xfer_s      = 1'b1;
          grant_idx_s = 1'b1;
        end else begin
          xfer_s      = 1'b0;
        end
        if (xfer_s) begin
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A reply wins over a simultaneous expiry.
        if (toggle_s) begin
          state_nx_s = ST_GAP;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s  = 1'b1;
          state_nx_s = ST_GAP;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_GAP;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Payload of the granted requester.
  always_comb begin
    grant_data_s = bus.req0_data;
    if (grant_idx_s) begin
      grant_data_s = bus.req1_data;
    end else begin
      grant_data_s = bus.req0_data;
    end
  end

  // Ready is combinational so the transfer completes on the grant edge.
  // It is held low while reset is asserted.
  assign bus.req0_ready = xfer_s & ~grant_idx_s & ~reset;
  assign bus.req1_ready = xfer_s &  grant_idx_s & ~reset;

  // WAIT cycle counter. It is cleared on transfer and saturates.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (xfer_s) begin
      cnt_r <= '0;
    end else if ((state_r == ST_WAIT) && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // GAP cycle counter. It sits at zero outside GAP.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      gap_cnt_r <= '0;
    end else if (state_r != ST_GAP) begin
      gap_cnt_r <= '0;
    end else if (gap_cnt_r != GAP_MAX) begin
      gap_cnt_r <= gap_cnt_r + 1'b1;
    end else begin
      gap_cnt_r <= gap_cnt_r;
    end
  end

  // Outgoing message register and round-robin memory.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cd_in_r      <= 49'd0;
      last_grant_r <= 1'b1;
    end else if (xfer_s) begin
      cd_in_r      <= {~cd_in_r[48], grant_data_s};
      last_grant_r <= grant_idx_s;
    end else begin
      cd_in_r      <= cd_in_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Incoming command decode. This runs in every state.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_tog_r   <= 1'b0;
      primed_r    <= 1'b0;
      cmd_valid_r <= 1'b0;
      cmd_data_r  <= 48'd0;
    end else begin
      old_tog_r   <= bus.cd_out[48];
      primed_r    <= 1'b1;
      cmd_valid_r <= toggle_s;
      if (toggle_s) begin
        cmd_data_r <= bus.cd_out[47:0];
      end else begin
        cmd_data_r <= cmd_data_r;
      end
    end
  end

  // Registered status strobes. busy follows the state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      timeout_evt_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      timeout_evt_r <= timeout_s;
      busy_r        <= (state_nx_s != ST_IDLE);
    end
  end

  assign bus.cd_in       = cd_in_r;
  assign bus.cmd_valid   = cmd_valid_r;
  assign bus.cmd_data    = cmd_data_r;
  assign bus.timeout_evt = timeout_evt_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_cd_link_sched.sv
// Randomized self-checking bench for cd_link_sched.
// The reference model tracks each message as a timestamped transaction.
// The message is granted at cycle t and must end by a reply or by
// t+TIMEOUT. The scheduler is free again GAP+1 cycles after it ends.
module tb_cd_link_sched;

  localparam int TO  = 8;
  localparam int GP  = 2;
  localparam int BIG = 32'h7fff_ffff;

  logic clk_sys = 1'b0;
  logic reset;

  cd_link_sched_if bus ();

  cd_link_sched #(.TIMEOUT(TO), .GAP(GP)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;

  // requester / HPS stimulus state
  bit          pend0, pend1;
  logic [47:0] dat0, dat1;
  bit          cd_tog;
  logic [47:0] cd_dat;
  int          p0_pct, p1_pct, tog_pct;

  // reference model
  int          cyc;
  int          m_free;
  bit          m_waiting;
  int          m_deadline;
  bit          m_last;
  logic [48:0] m_cd_in;
  bit          m_cmd_valid;
  logic [47:0] m_cmd_data;
  bit          m_tev;
  bit          m_prev_tog;
  logic [48:0] snap_cd_in;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  task automatic apply();
    bus.req0_valid = pend0;
    bus.req0_data  = dat0;
    bus.req1_valid = pend1;
    bus.req1_data  = dat1;
    bus.cd_out     = {cd_tog, cd_dat};
  endtask

  task automatic gen_stim();
    if (!pend0 && ($urandom_range(99) < p0_pct)) begin
      pend0 = 1'b1;
      dat0  = rand48();
    end
    if (!pend1 && ($urandom_range(99) < p1_pct)) begin
      pend1 = 1'b1;
      dat1  = rand48();
    end
    if ($urandom_range(99) < tog_pct) begin
      cd_tog = ~cd_tog;
      cd_dat = rand48();
    end
  endtask

  task automatic model_reset();
    cyc         = 0;
    m_free      = 0;
    m_waiting   = 1'b0;
    m_deadline  = 0;
    m_last      = 1'b1;
    m_cd_in     = 49'd0;
    m_cmd_valid = 1'b0;
    m_cmd_data  = 48'd0;
    m_tev       = 1'b0;
  endtask

  // Compare one cycle, then advance the model to the next cycle.
  task automatic compare_update();
    bit busy_e, g_valid, g, tdet;
    busy_e  = (cyc < m_free);
    g_valid = !busy_e && (pend0 || pend1);
    g       = (pend0 && pend1) ? !m_last : !pend0;
    check_val("req0_ready", 64'(bus.req0_ready), 64'(g_valid && !g));
    check_val("req1_ready", 64'(bus.req1_ready), 64'(g_valid && g));
    check_val("cd_in", 64'(bus.cd_in), 64'(m_cd_in));
    check_val("busy", 64'(bus.busy), 64'(busy_e));
    check_val("cmd_valid", 64'(bus.cmd_valid), 64'(m_cmd_valid));
    check_val("cmd_data", 64'(bus.cmd_data), 64'(m_cmd_data));
    check_val("timeout_evt", 64'(bus.timeout_evt), 64'(m_tev));

    tdet  = (cyc >= 1) && (cd_tog != m_prev_tog);
    m_tev = 1'b0;
    if (m_waiting) begin
      if (tdet) begin
        m_waiting = 1'b0;
        m_free    = cyc + GP + 1;
      end else if (cyc == m_deadline) begin
        m_waiting = 1'b0;
        m_tev     = 1'b1;
        m_free    = cyc + GP + 1;
      end
    end
    m_cmd_valid = tdet;
    if (tdet) m_cmd_data = cd_dat;
    if (g_valid) begin
      m_cd_in    = {~m_cd_in[48], (g ? dat1 : dat0)};
      m_last     = g;
      m_waiting  = 1'b1;
      m_deadline = cyc + TO;
      m_free     = BIG;
      if (g) pend1 = 1'b0;
      else   pend0 = 1'b0;
    end
    m_prev_tog = cd_tog;
    cyc++;
  endtask

  task automatic run(input int k);
    repeat (k) begin
      @(negedge clk_sys);
      compare_update();
      @(posedge clk_sys);
      #1;
      gen_stim();
      apply();
    end
  endtask

  initial begin
    pend0 = 1'b0; pend1 = 1'b0; dat0 = 48'd0; dat1 = 48'd0;
    cd_tog = 1'b0; cd_dat = 48'd0;
    p0_pct = 0; p1_pct = 0; tog_pct = 0;
    model_reset();
    m_prev_tog = 1'b0;
    reset = 1'b1;
    apply();

    // reset values, with both requesters asking
    repeat (2) @(posedge clk_sys);
    #1;
    pend0 = 1'b1; pend1 = 1'b1;
    apply();
    #1;
    check_val("rst_cd_in", 64'(bus.cd_in), 64'd0);
    check_val("rst_cmd_data", 64'(bus.cmd_data), 64'd0);
    check_val("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check_val("rst_timeout", 64'(bus.timeout_evt), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_ready0", 64'(bus.req0_ready), 64'd0);
    check_val("rst_ready1", 64'(bus.req1_ready), 64'd0);

    // single message from requester 0
    pend1 = 1'b0;
    dat0  = 48'h0000_1234_5678;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    model_reset();
    apply();
    run(1);
    check_val("single_cd_in", 64'(bus.cd_in), 64'h1_0000_1234_5678);
    check_val("single_busy", 64'(bus.busy), 64'd1);
    run(2);

    // reply path
    cd_tog = ~cd_tog;
    cd_dat = 48'hABCD;
    apply();
    run(1);
    check_val("reply_cmd_valid", 64'(bus.cmd_valid), 64'd1);
    check_val("reply_cmd_data", 64'(bus.cmd_data), 64'hABCD);
    run(6);

    // round-robin under constant contention, with no replies (timeouts)
    p0_pct = 100; p1_pct = 100; tog_pct = 0;
    pend0 = 1'b1; dat0 = rand48();
    pend1 = 1'b1; dat1 = rand48();
    apply();
    run(80);

    // unsolicited command in IDLE
    p0_pct = 0; p1_pct = 0;
    for (int i = 0; i < 60; i++) begin
      if (cyc >= m_free && !pend0 && !pend1) break;
      run(1);
    end
    snap_cd_in = bus.cd_in;
    cd_tog = ~cd_tog;
    cd_dat = rand48();
    apply();
    run(3);
    check_val("unsol_cd_in", 64'(bus.cd_in), 64'(snap_cd_in));
    check_val("unsol_busy", 64'(bus.busy), 64'd0);

    // reset mid-WAIT with cd_out[48] high
    if (!cd_tog) begin
      cd_tog = 1'b1;
      apply();
      run(3);
    end
    pend0 = 1'b1; dat0 = rand48();
    apply();
    run(4);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_cd_in", 64'(bus.cd_in), 64'd0);
    check_val("midrst_busy", 64'(bus.busy), 64'd0);
    check_val("midrst_cmd_data", 64'(bus.cmd_data), 64'd0);
    check_val("midrst_ready0", 64'(bus.req0_ready), 64'd0);
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    model_reset();
    pend0 = 1'b1; dat0 = rand48();
    pend1 = 1'b1; dat1 = rand48();
    apply();
    run(30);

    // random traffic with frequent replies, then sparse replies
    p0_pct = 30; p1_pct = 30; tog_pct = 15;
    run(1500);
    tog_pct = 3;
    run(600);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
